// File: rtl/icache_fetch_if.sv
// Fetch-stage bundle: global enable, redirect, memory fill channel and decoder output.
interface icache_fetch_if;
  logic         rdy;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         mem_req;
  logic [31:0]  mem_pc;
  logic [511:0] mem_row;
  logic         mem_done;
  logic         dec_stall;
  logic         inst_valid;
  logic [31:0]  inst;
  logic [31:0]  inst_pc;

  modport master (
    input  rdy, redirect, redirect_pc, mem_row, mem_done, dec_stall,
    output mem_req, mem_pc, inst_valid, inst, inst_pc
  );

  modport slave (
    output rdy, redirect, redirect_pc, mem_row, mem_done, dec_stall,
    input  mem_req, mem_pc, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/icache_fetch.sv
// Instruction fetch stage with a direct-mapped cache of 64-byte lines.
// Delivers one 32-bit instruction per cycle on hit; fills whole lines on miss.
module icache_fetch #(
  parameter int unsigned LINES    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic           clk,
  input  logic           rst,
  icache_fetch_if.master bus
);
  localparam int unsigned IDX    = $clog2(LINES);
  localparam int unsigned TAG_W  = 32 - 6 - IDX;
  localparam int unsigned LINE_W = 512;

  typedef enum logic [0:0] {FETCH, MISS} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_pc_q, mem_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  logic [IDX-1:0]   lk_idx_c, fill_idx_c;
  logic [TAG_W-1:0] lk_tag_c, fill_tag_c;
  logic             hit_c, fill_c, hold_c;
  logic [31:0]      word_c;

  // Lookup of the current pc and fill addressing from the latched miss pc.
  assign lk_idx_c   = pc_q[6 +: IDX];
  assign lk_tag_c   = pc_q[31 -: TAG_W];
  assign fill_idx_c = mem_pc_q[6 +: IDX];
  assign fill_tag_c = mem_pc_q[31 -: TAG_W];
  assign hit_c      = valid_q[lk_idx_c] && (tag_q[lk_idx_c] == lk_tag_c);
  assign word_c     = data_q[lk_idx_c][{pc_q[5:2], 5'd0} +: 32];
  assign hold_c     = inst_valid_q && bus.dec_stall;

  // A completing fill installs even when a redirect lands in the same cycle.
  assign fill_c = bus.rdy && (state_q == MISS) && bus.mem_done;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    mem_req_d    = mem_req_q;
    mem_pc_d     = mem_pc_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    if (bus.rdy) begin
      if (bus.redirect) begin
        pc_d         = bus.redirect_pc;
        inst_valid_d = 1'b0;
        mem_req_d    = 1'b0;
        state_d      = FETCH;
      end else if (fill_c) begin
        mem_req_d = 1'b0;
        state_d   = FETCH;
      end else if ((state_q == FETCH) && !hold_c) begin
        if (hit_c) begin
          inst_valid_d = 1'b1;
          inst_d       = word_c;
          inst_pc_d    = pc_q;
          pc_d         = pc_q + 32'd4;
        end else begin
          inst_valid_d = 1'b0;
          mem_pc_d     = pc_q;
          mem_req_d    = 1'b1;
          state_d      = MISS;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      mem_req_q    <= 1'b0;
      mem_pc_q     <= 32'h0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      mem_req_q    <= mem_req_d;
      mem_pc_q     <= mem_pc_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_c) begin
      valid_q[fill_idx_c] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (fill_c) begin
      tag_q[fill_idx_c]  <= fill_tag_c;
      data_q[fill_idx_c] <= bus.mem_row;
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_pc     = mem_pc_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
endmodule

// File: tb/tb_icache_fetch.sv
// Scoreboard bench for icache_fetch: reference stream of PCs, memory model, random traffic.
module tb_icache_fetch;
  localparam int unsigned LINES = 4;

  logic clk = 1'b0;
  logic rst;
  icache_fetch_if bus();

  icache_fetch #(.LINES(LINES), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned consumed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;
  bit          resp_hold = 1'b0;

  // Backing memory: every word is a unique function of its byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h100 + (a >> 2);
  endfunction

  function automatic logic [511:0] line_row(input logic [31:0] a);
    logic [511:0] r;
    logic [31:0]  base;
    base = {a[31:6], 6'd0};
    for (int i = 0; i < 16; i++) r[32*i +: 32] = mem_word(base + 32'(4*i));
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name, input int unsigned max_cyc, input logic [31:0] pc);
    int unsigned i = 0;
    while (!bus.mem_req && i < max_cyc) begin cyc(); i++; end
    check({name, "_req"}, 32'(bus.mem_req), 32'd1);
    check({name, "_pc"}, bus.mem_pc, pc);
  endtask

  task automatic wait_inst(input logic [31:0] pc, input int unsigned max_cyc);
    int unsigned i = 0;
    while (!(bus.inst_valid && bus.inst_pc == pc) && i < max_cyc) begin cyc(); i++; end
    check("reach_inst_pc", bus.inst_pc, pc);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    bus.redirect    = 1'b1;
    bus.redirect_pc = pc;
    cyc();
    bus.redirect    = 1'b0;
  endtask

  // Reference model: the architectural PC sequence the decoder must receive.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        model_pc = 32'h0;
      end else if (bus.rdy && bus.redirect) begin
        exp_q.delete();
        model_pc = bus.redirect_pc;
      end
      while (exp_q.size() < 4) begin
        exp_q.push_back(model_pc);
        model_pc += 32'd4;
      end
    end
  end

  // Monitor: every accepted instruction pops one expected PC; misses must request that PC.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.rdy && bus.inst_valid && !bus.dec_stall && !bus.redirect) begin
          if (exp_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("inst_pc", bus.inst_pc, e);
            check("inst", bus.inst, mem_word(e));
            consumed++;
          end
        end
        if (bus.mem_req && exp_q.size() != 0) check("mem_pc", bus.mem_pc, exp_q[0]);
      end
    end
  end

  // Memory controller: random latency, and a stale corrupted pulse after each request drops.
  initial begin
    int unsigned wait_cnt = 2;
    bit          req_seen = 1'b0;
    logic [31:0] req_pc   = 32'h0;
    bus.mem_done = 1'b0;
    bus.mem_row  = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.mem_done = 1'b0;
      if (bus.mem_req) begin
        req_seen = 1'b1;
        req_pc   = bus.mem_pc;
        if (!resp_hold) begin
          if (wait_cnt == 0) begin
            bus.mem_row  = line_row(bus.mem_pc);
            bus.mem_done = 1'b1;
            wait_cnt     = $urandom_range(0, 4);
          end else begin
            wait_cnt--;
          end
        end
      end else if (req_seen) begin
        req_seen     = 1'b0;
        bus.mem_row  = ~line_row(req_pc);
        bus.mem_done = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.rdy         = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.dec_stall   = 1'b0;
    rst             = 1'b1;
    repeat (3) cyc();
    check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_pc", bus.mem_pc, 32'h0);
    check("rst_inst", bus.inst, 32'h0);
    check("rst_inst_pc", bus.inst_pc, 32'h0);
    rst     = 1'b0;
    bus.rdy = 1'b1;

    // Cold miss on the reset PC, then a full line streamed before the next-line miss.
    wait_req("cold", 2, 32'h0);
    for (int i = 0; i < 20 && !bus.inst_valid; i++) cyc();
    resp_hold = 1'b1;
    wait_req("line_cross", 30, 32'h40);
    check("line0_count", consumed, 32'd16);

    // Redirect during an outstanding fill abandons it.
    repeat (2) cyc();
    do_redirect(32'h100);
    check("abort_req_drop", 32'(bus.mem_req), 32'd0);
    wait_req("redir", 3, 32'h100);
    resp_hold = 1'b0;
    wait_inst(32'h110, 30);

    // 0x000 aliases 0x100 in index 0 and must miss again.
    do_redirect(32'h0);
    check("redir_flush", 32'(bus.inst_valid), 32'd0);
    wait_req("alias", 3, 32'h0);

    // Decoder stall holds the presented instruction.
    wait_inst(32'h8, 30);
    bus.dec_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_valid", 32'(bus.inst_valid), 32'd1);
      check("stall_pc", bus.inst_pc, 32'h8);
      check("stall_inst", bus.inst, 32'h102);
    end
    bus.dec_stall = 1'b0;

    // Global enable low in the middle of a hit stream.
    wait_inst(32'h10, 20);
    bus.rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("frz_hit_valid", 32'(bus.inst_valid), 32'd1);
      check("frz_hit_pc", bus.inst_pc, 32'h10);
      check("frz_hit_inst", bus.inst, mem_word(32'h10));
    end
    bus.rdy = 1'b1;

    // The aborted 0x40 fill and its stale pulse must not have installed anything.
    resp_hold = 1'b1;
    do_redirect(32'h40);
    wait_req("no_install", 3, 32'h40);
    bus.rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("frz_miss_req", 32'(bus.mem_req), 32'd1);
      check("frz_miss_pc", bus.mem_pc, 32'h40);
      check("frz_miss_valid", 32'(bus.inst_valid), 32'd0);
    end
    bus.rdy   = 1'b1;
    resp_hold = 1'b0;
    wait_inst(32'h44, 20);

    // Random traffic: enable gaps, stalls, redirects incl. near the 32-bit wrap.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      bus.rdy       = ($urandom_range(0, 9) != 0);
      bus.dec_stall = ($urandom_range(0, 3) == 0);
      bus.redirect  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0)
        bus.redirect_pc = 32'hFFFF_FFC0 + (32'($urandom_range(0, 15)) << 2);
      else
        bus.redirect_pc = 32'($urandom_range(0, 255)) << 2;
    end
    bus.rdy       = 1'b1;
    bus.dec_stall = 1'b0;
    bus.redirect  = 1'b0;
    repeat (20) cyc();
    check("progress", 32'(consumed > 500), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
